// File: rtl/dmem_port_arbiter_pkg.sv
// Shared definitions for the data-memory port arbiter: FSM states, port ids,
// default memory size and access-size codes.
package dmem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    typedef enum logic {
        SIZE_WORD = 1'b0,
        SIZE_BYTE = 1'b1
    } size_t;

    localparam logic PORT_CPU      = 1'b0;
    localparam logic PORT_DBG      = 1'b1;
    localparam int   MEM_BYTES_DEF = 256;

endpackage

// File: rtl/dmem_port_arbiter_rr_picker.sv
// Two-input tie-break for the arbiter. With DMEM_ARB_RR_EN defined the port not
// granted last wins a tie; otherwise port 0 always wins and the pointer is ignored.
module dmem_port_arbiter_rr_picker (
    input  logic valid0,
    input  logic valid1,
    input  logic last_grant,
    output logic grant
);
`ifdef DMEM_ARB_RR_EN
    assign grant = (valid0 & valid1) ? ~last_grant : valid1;
`else
    logic unused_last_grant;
    assign unused_last_grant = last_grant;
    assign grant             = valid1 & ~valid0;
`endif
endmodule

// File: rtl/dmem_port_arbiter.sv
// Shares one byte-addressed data memory between the CPU port (0) and the debug
// port (1), one access at a time. Arbitration mode selected by DMEM_ARB_RR_EN.
module dmem_port_arbiter
    import dmem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int MEM_BYTES = MEM_BYTES_DEF
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              i_Req0_valid,
    output logic              o_Req0_ready,
    input  logic              i_Req0_we,
    input  logic              i_Req0_sByte,
    input  logic [ADDR_W-1:0] i_Req0_addr,
    input  logic [DATA_W-1:0] i_Req0_wData,
    output logic              o_Rsp0_valid,
    input  logic              i_Rsp0_ready,
    output logic [DATA_W-1:0] o_Rsp0_rData,
    output logic              o_Rsp0_err,
    input  logic              i_Req1_valid,
    output logic              o_Req1_ready,
    input  logic              i_Req1_we,
    input  logic              i_Req1_sByte,
    input  logic [ADDR_W-1:0] i_Req1_addr,
    input  logic [DATA_W-1:0] i_Req1_wData,
    output logic              o_Rsp1_valid,
    input  logic              i_Rsp1_ready,
    output logic [DATA_W-1:0] o_Rsp1_rData,
    output logic              o_Rsp1_err,
    output logic              o_DMem_we,
    output logic              o_DMem_sByte,
    output logic [ADDR_W-1:0] o_DMem_addr,
    output logic [DATA_W-1:0] o_DMem_wData,
    input  logic [DATA_W-1:0] i_DMem_rData
);
    localparam logic [ADDR_W-1:0] TOP_ADDR  = ADDR_W'(MEM_BYTES);
    localparam logic [ADDR_W-1:0] LAST_WORD = ADDR_W'(MEM_BYTES - 4);

    state_t            state_reg, state_next;
    logic              run_reg, grant_reg, last_grant_reg, win, win_err;
    logic              both_valid, accept;
    logic              lat_we_reg, lat_sbyte_reg, lat_err_reg;
    logic [ADDR_W-1:0] lat_addr_reg;
    logic [DATA_W-1:0] lat_wdata_reg, rsp_cap;
    logic [1:0]        req_valid, req_we, req_sbyte, req_ready, rsp_ready, rsp_valid;
    logic [ADDR_W-1:0] req_addr     [2];
    logic [DATA_W-1:0] req_wdata    [2];
    logic [DATA_W-1:0] rsp_data_reg [2];
    logic [1:0]        rsp_err_reg;

    assign req_valid    = {i_Req1_valid, i_Req0_valid};
    assign req_we       = {i_Req1_we, i_Req0_we};
    assign req_sbyte    = {i_Req1_sByte, i_Req0_sByte};
    assign rsp_ready    = {i_Rsp1_ready, i_Rsp0_ready};
    assign req_addr[0]  = i_Req0_addr;
    assign req_addr[1]  = i_Req1_addr;
    assign req_wdata[0] = i_Req0_wData;
    assign req_wdata[1] = i_Req1_wData;

    dmem_port_arbiter_rr_picker u_picker (
        .valid0     (req_valid[0]),
        .valid1     (req_valid[1]),
        .last_grant (last_grant_reg),
        .grant      (win)
    );

    // run_reg keeps every ready low until the first edge after reset release
    assign both_valid = &req_valid;
    assign accept     = (state_reg == ST_IDLE) & run_reg & (|req_valid);
    assign win_err    = (req_addr[win] >= TOP_ADDR)
                      | (~req_sbyte[win] & (req_addr[win] > LAST_WORD));

    for (genvar gi = 0; gi < 2; gi++) begin : g_port
        assign req_ready[gi] = (state_reg == ST_IDLE) & run_reg
                             & ~(both_valid & (win != 1'(gi)));
        assign rsp_valid[gi] = (state_reg == ST_RESP) & (grant_reg == 1'(gi));
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:   if (accept) state_next = ST_ACCESS;
            ST_ACCESS: state_next = ST_RESP;
            ST_RESP:   if (rsp_ready[grant_reg]) state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        rsp_cap = '0;
        if (!lat_we_reg && !lat_err_reg) begin
            rsp_cap = (lat_sbyte_reg == SIZE_BYTE) ? {{(DATA_W-8){1'b0}}, i_DMem_rData[7:0]}
                                                   : i_DMem_rData;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_reg      <= ST_IDLE;
            run_reg        <= 1'b0;
            grant_reg      <= PORT_CPU;
            last_grant_reg <= PORT_DBG;
            lat_we_reg     <= 1'b0;
            lat_sbyte_reg  <= 1'b0;
            lat_err_reg    <= 1'b0;
            lat_addr_reg   <= '0;
            lat_wdata_reg  <= '0;
        end else begin
            state_reg <= state_next;
            run_reg   <= 1'b1;
            if (accept) begin
                grant_reg      <= win;
                last_grant_reg <= win;
                lat_we_reg     <= req_we[win];
                lat_sbyte_reg  <= req_sbyte[win];
                lat_err_reg    <= win_err;
                lat_addr_reg   <= req_addr[win];
                lat_wdata_reg  <= req_wdata[win];
            end
        end
    end

    // Response registers capture the combinational memory read at the end of ACCESS
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rsp_data_reg[0] <= '0;
            rsp_data_reg[1] <= '0;
            rsp_err_reg     <= '0;
        end else if (state_reg == ST_ACCESS) begin
            rsp_data_reg[grant_reg] <= rsp_cap;
            rsp_err_reg[grant_reg]  <= lat_err_reg;
        end
    end

    assign o_Req0_ready = req_ready[0];
    assign o_Req1_ready = req_ready[1];
    assign o_Rsp0_valid = rsp_valid[0];
    assign o_Rsp1_valid = rsp_valid[1];
    assign o_Rsp0_rData = rsp_data_reg[0];
    assign o_Rsp1_rData = rsp_data_reg[1];
    assign o_Rsp0_err   = rsp_err_reg[0];
    assign o_Rsp1_err   = rsp_err_reg[1];
    assign o_DMem_we    = (state_reg == ST_ACCESS) & lat_we_reg & ~lat_err_reg;
    assign o_DMem_sByte = lat_sbyte_reg;
    assign o_DMem_addr  = lat_addr_reg;
    assign o_DMem_wData = lat_wdata_reg;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Scoreboard bench for dmem_port_arbiter with a 256-byte memory model; expects
// round-robin grants when DMEM_ARB_RR_EN is defined, fixed priority otherwise.
module tb_dmem_port_arbiter;

    typedef struct {
        int          port;
        logic [31:0] data;
        logic        err;
        int          acc_edge;
        logic        we;
        logic        sbyte;
        logic [31:0] addr;
        logic [31:0] wdata;
    } sb_t;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic [1:0]  req_valid, req_we, req_sbyte, rsp_ready;
    logic [1:0]  req_ready, rsp_valid, rsp_err;
    logic [31:0] req_addr  [2];
    logic [31:0] req_wdata [2];
    logic [31:0] rsp_rdata [2];
    logic        dmem_we, dmem_sbyte;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;

    logic [7:0]  mem     [256];
    logic [7:0]  ref_mem [256];
    sb_t         sb_q[$];
    int          grant_log[$];
    int          checks = 0, errors = 0, cyc = 0, we_pulses = 0;
    int          acc_cnt [2];
    int          hs_edge [2];
    int          last_acc_edge [2];
    logic [31:0] last_data [2];
    logic        last_err [2];
    logic        rsp_seen = 1'b0;
    int          first_edge = 0;
    sb_t         mon_e;
    logic [7:0]  mon_a8;

    dmem_port_arbiter dut (
        .clk          (clk),
        .rstn         (rstn),
        .i_Req0_valid (req_valid[0]),
        .o_Req0_ready (req_ready[0]),
        .i_Req0_we    (req_we[0]),
        .i_Req0_sByte (req_sbyte[0]),
        .i_Req0_addr  (req_addr[0]),
        .i_Req0_wData (req_wdata[0]),
        .o_Rsp0_valid (rsp_valid[0]),
        .i_Rsp0_ready (rsp_ready[0]),
        .o_Rsp0_rData (rsp_rdata[0]),
        .o_Rsp0_err   (rsp_err[0]),
        .i_Req1_valid (req_valid[1]),
        .o_Req1_ready (req_ready[1]),
        .i_Req1_we    (req_we[1]),
        .i_Req1_sByte (req_sbyte[1]),
        .i_Req1_addr  (req_addr[1]),
        .i_Req1_wData (req_wdata[1]),
        .o_Rsp1_valid (rsp_valid[1]),
        .i_Rsp1_ready (rsp_ready[1]),
        .o_Rsp1_rData (rsp_rdata[1]),
        .o_Rsp1_err   (rsp_err[1]),
        .o_DMem_we    (dmem_we),
        .o_DMem_sByte (dmem_sbyte),
        .o_DMem_addr  (dmem_addr),
        .o_DMem_wData (dmem_wdata),
        .i_DMem_rData (dmem_rdata)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Memory model: word reads/writes little-endian, bytes beyond the top read as 0
    always @(posedge clk) begin
        if (dmem_we) begin
            if (dmem_sbyte) begin
                if (dmem_addr < 32'd256) mem[dmem_addr[7:0]] <= dmem_wdata[7:0];
            end else begin
                for (int i = 0; i < 4; i++)
                    if (dmem_addr <= 32'(255 - i)) mem[dmem_addr[7:0] + 8'(i)] <= dmem_wdata[8*i +: 8];
            end
        end
    end

    always_comb begin
        dmem_rdata = '0;
        for (int i = 0; i < 4; i++)
            if (dmem_addr <= 32'(255 - i)) dmem_rdata[8*i +: 8] = mem[dmem_addr[7:0] + 8'(i)];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Monitor: predicts at acceptance, compares at response handshake
    always @(negedge clk) begin
        if (rstn) begin
            if (&req_valid && |req_ready)
                check("loser_ready", 32'(req_ready[0] & req_ready[1]), 32'd0);
            for (int p = 0; p < 2; p++) begin
                if (req_valid[p] && req_ready[p]) begin
                    mon_e.port     = p;
                    mon_e.we       = req_we[p];
                    mon_e.sbyte    = req_sbyte[p];
                    mon_e.addr     = req_addr[p];
                    mon_e.wdata    = req_wdata[p];
                    mon_e.acc_edge = cyc + 1;
                    mon_e.err      = (req_addr[p] >= 32'd256) || (!req_sbyte[p] && req_addr[p] > 32'd252);
                    mon_a8         = req_addr[p][7:0];
                    if (req_we[p] || mon_e.err) mon_e.data = 32'd0;
                    else if (req_sbyte[p])      mon_e.data = {24'd0, ref_mem[mon_a8]};
                    else mon_e.data = {ref_mem[mon_a8 + 8'd3], ref_mem[mon_a8 + 8'd2],
                                       ref_mem[mon_a8 + 8'd1], ref_mem[mon_a8]};
                    sb_q.push_back(mon_e);
                    grant_log.push_back(p);
                    acc_cnt[p]++;
                    last_acc_edge[p] = cyc + 1;
                end
            end
            if (|rsp_valid && !rsp_seen) begin
                rsp_seen   = 1'b1;
                first_edge = cyc + 1;
            end
            if (dmem_we) we_pulses++;
            for (int p = 0; p < 2; p++) begin
                if (rsp_valid[p] && rsp_ready[p]) begin
                    check("sb_nonempty", 32'(sb_q.size() > 0), 32'd1);
                    if (sb_q.size() > 0) begin
                        mon_e = sb_q.pop_front();
                        check("rsp_port", 32'(p), 32'(mon_e.port));
                        check("rsp_data", rsp_rdata[p], mon_e.data);
                        check("rsp_err", 32'(rsp_err[p]), 32'(mon_e.err));
                        check("rsp_latency", 32'(first_edge), 32'(mon_e.acc_edge + 2));
                        if (mon_e.we && !mon_e.err) begin
                            if (mon_e.sbyte) ref_mem[mon_e.addr[7:0]] = mon_e.wdata[7:0];
                            else for (int i = 0; i < 4; i++)
                                ref_mem[mon_e.addr[7:0] + 8'(i)] = mon_e.wdata[8*i +: 8];
                        end
                        $display("txn port%0d we=%0d byte=%0d addr=0x%08h rdata=0x%08h err=%0d",
                                 p, mon_e.we, mon_e.sbyte, mon_e.addr, rsp_rdata[p], rsp_err[p]);
                    end
                    last_data[p] = rsp_rdata[p];
                    last_err[p]  = rsp_err[p];
                    hs_edge[p]   = cyc + 1;
                    rsp_seen     = 1'b0;
                end
            end
        end
    end

    task automatic issue(input int p, input logic we, input logic sb,
                         input logic [31:0] addr, input logic [31:0] wdata);
        int n;
        @(posedge clk); #1;
        req_we[p] = we; req_sbyte[p] = sb; req_addr[p] = addr; req_wdata[p] = wdata;
        req_valid[p] = 1'b1;
        n = acc_cnt[p];
        for (int k = 0; k < 50; k++) begin
            @(posedge clk); #1;
            if (acc_cnt[p] != n) break;
        end
        check("accepted", 32'(acc_cnt[p] - n), 32'd1);
        req_valid[p] = 1'b0;
    endtask

    task automatic wait_done();
        for (int k = 0; k < 50; k++) begin
            @(posedge clk); #1;
            if (sb_q.size() == 0 && rsp_valid == 2'b00) break;
        end
        check("drained", 32'(sb_q.size()), 32'd0);
    endtask

    task automatic both_grants(input int count);
        int n;
        n = acc_cnt[0] + acc_cnt[1];
        for (int k = 0; k < 40 * count; k++) begin
            @(posedge clk); #1;
            if (acc_cnt[0] + acc_cnt[1] - n >= count) break;
        end
        check("grant_count", 32'(acc_cnt[0] + acc_cnt[1] - n), 32'(count));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int w0;
        for (int i = 0; i < 256; i++) begin mem[i] = 8'd0; ref_mem[i] = 8'd0; end
        acc_cnt[0] = 0; acc_cnt[1] = 0;
        req_valid = 2'b00; req_we = 2'b00; req_sbyte = 2'b00; rsp_ready = 2'b11;
        req_addr[0] = 0; req_addr[1] = 0; req_wdata[0] = 0; req_wdata[1] = 0;

        repeat (2) @(negedge clk);
        check("rst_ready", 32'(req_ready), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_dmem_we", 32'(dmem_we), 32'd0);
        check("rst_dmem_addr", dmem_addr, 32'd0);
        rstn = 1'b1;
        repeat (2) @(negedge clk);
        check("idle_ready", 32'(req_ready), 32'd3);

        // 1: word store then word load
        issue(0, 1'b1, 1'b0, 32'h10, 32'hDEADBEEF); wait_done();
        issue(0, 1'b0, 1'b0, 32'h10, 32'h0);        wait_done();
        check("t1_load", last_data[0], 32'hDEADBEEF);
        check("t1_err", 32'(last_err[0]), 32'd0);

        // 2: debug byte store, CPU word and byte loads; end on a port-1 grant
        issue(1, 1'b1, 1'b1, 32'h11, 32'h000000A5); wait_done();
        issue(0, 1'b0, 1'b0, 32'h10, 32'h0);        wait_done();
        check("t2_word", last_data[0], 32'hDEADA5EF);
        issue(0, 1'b0, 1'b1, 32'h11, 32'h0);        wait_done();
        check("t2_byte", last_data[0], 32'h000000A5);
        issue(1, 1'b0, 1'b1, 32'h10, 32'h0);        wait_done();
        check("t2_byte1", last_data[1], 32'h000000EF);

        // 3: both valid continuously for six grants
        grant_log.delete();
        @(posedge clk); #1;
        req_we = 2'b00; req_sbyte = 2'b00; req_addr[0] = 32'h10; req_addr[1] = 32'h10;
        req_valid = 2'b11;
        both_grants(6);
        req_valid = 2'b00;
        wait_done();
        check("t3_glen", 32'(grant_log.size()), 32'd6);
        for (int i = 0; i < 6 && i < grant_log.size(); i++) begin
`ifdef DMEM_ARB_RR_EN
            check("t3_grant", 32'(grant_log[i]), 32'(i % 2));
`else
            check("t3_grant", 32'(grant_log[i]), 32'd0);
`endif
        end

        // 4: range check at the top of memory
        w0 = we_pulses;
        issue(0, 1'b1, 1'b0, 32'hFD, 32'h12345678); wait_done();
        check("t4_wst_err", 32'(last_err[0]), 32'd1);
        check("t4_wst_data", last_data[0], 32'd0);
        issue(1, 1'b0, 1'b1, 32'h100, 32'h0);       wait_done();
        check("t4_bld_err", 32'(last_err[1]), 32'd1);
        issue(0, 1'b0, 1'b0, 32'hFD, 32'h0);        wait_done();
        check("t4_wld_err", 32'(last_err[0]), 32'd1);
        check("t4_no_we", 32'(we_pulses - w0), 32'd0);
        issue(1, 1'b1, 1'b1, 32'hFF, 32'h0000003C); wait_done();
        check("t4_bst_err", 32'(last_err[1]), 32'd0);
        check("t4_one_we", 32'(we_pulses - w0), 32'd1);
        issue(0, 1'b0, 1'b1, 32'hFF, 32'h0);        wait_done();
        check("t4_bld_ff", last_data[0], 32'h0000003C);
        issue(0, 1'b0, 1'b0, 32'hFC, 32'h0);        wait_done();
        check("t4_wld_fc", last_data[0], 32'h3C000000);
        check("t4_wld_fc_err", 32'(last_err[0]), 32'd0);

        // 5: CPU response held off while the debug port waits
        rsp_ready[0] = 1'b0;
        issue(0, 1'b0, 1'b0, 32'h10, 32'h0);
        req_we[1] = 1'b0; req_sbyte[1] = 1'b1; req_addr[1] = 32'h11; req_valid[1] = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk); #1;
            if (rsp_valid[0]) break;
        end
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("t5_hold_valid", 32'(rsp_valid[0]), 32'd1);
            check("t5_hold_data", rsp_rdata[0], 32'hDEADA5EF);
            check("t5_p1_ready", 32'(req_ready[1]), 32'd0);
        end
        @(posedge clk); #1;
        rsp_ready[0] = 1'b1;
        w0 = acc_cnt[1];
        for (int k = 0; k < 20; k++) begin
            @(posedge clk); #1;
            if (acc_cnt[1] != w0) break;
        end
        req_valid[1] = 1'b0;
        check("t5_p1_after_hs", 32'(last_acc_edge[1]), 32'(hs_edge[0] + 1));
        wait_done();
        check("t5_p1_data", last_data[1], 32'h000000A5);

        // 6: reset during the ACCESS cycle of a store
        issue(1, 1'b1, 1'b1, 32'h20, 32'h00000077);
        #2 rstn = 1'b0;
        #1;
        check("t6_ready", 32'(req_ready), 32'd0);
        check("t6_dmem_we", 32'(dmem_we), 32'd0);
        check("t6_dmem_addr", dmem_addr, 32'd0);
        check("t6_dmem_wdata", dmem_wdata, 32'd0);
        check("t6_dmem_sbyte", 32'(dmem_sbyte), 32'd0);
        check("t6_rsp_valid", 32'(rsp_valid), 32'd0);
        sb_q.delete();
        rsp_seen = 1'b0;
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        repeat (2) @(negedge clk);
        check("t6_mem", 32'(mem[8'h20]), 32'd0);
        grant_log.delete();
        @(posedge clk); #1;
        req_we = 2'b00; req_sbyte = 2'b11; req_addr[0] = 32'h20; req_addr[1] = 32'h21;
        req_valid = 2'b11;
        both_grants(1);
        req_valid[0] = 1'b0;
        check("t6_first_grant", 32'(grant_log.size() > 0 ? grant_log[0] : 9), 32'd0);
        w0 = acc_cnt[1];
        for (int k = 0; k < 20; k++) begin
            @(posedge clk); #1;
            if (acc_cnt[1] != w0) break;
        end
        req_valid[1] = 1'b0;
        wait_done();
        check("t6_byte20", last_data[0], 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
